// File: rtl/nco_pkg.sv
// Shared state encoding, default widths and latched-config record for the
// NCO sweep sequencer.
package nco_pkg;
  localparam int ACC_W_DEF   = 32;
  localparam int DWELL_W_DEF = 16;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_ARM, S_FINAL} nco_state_e;

  // Dwell is stored already clamped to a minimum of 1.
  typedef struct packed {
    logic [ACC_W_DEF-1:0]   start;
    logic [ACC_W_DEF-1:0]   step;
    logic [CNT_W_DEF-1:0]   count;
    logic [DWELL_W_DEF-1:0] dwell;
    logic                   loop;
  } nco_cfg_t;
endpackage

// File: rtl/nco_accum.sv
// Phase accumulator: carry-out flags a wrap, the MSB is registered once more
// before it reaches the output pin.
module nco_accum #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_wrap,
  output logic             o_msb
);
  logic [ACC_W-1:0] r_acc;
  logic             r_msb;
  logic [ACC_W:0]   w_sum;

  assign w_sum  = {1'b0, r_acc} + {1'b0, i_inc};
  assign o_wrap = w_sum[ACC_W];
  assign o_msb  = r_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_msb <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_msb <= 1'b0;
    end else begin
      r_msb <= r_acc[ACC_W-1];
      if (i_en) r_acc <= w_sum[ACC_W-1:0];
    end
  end
endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: walks the NCO increment through a programmed
// sweep, changing it only on accumulator wraps so clk_out stays continuous.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_start,
  input  logic [ACC_W-1:0]   cfg_step,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               abort,
  output logic               clk_out,
  output logic [ACC_W-1:0]   phase_inc,
  output logic [CNT_W-1:0]   step_idx,
  output logic               busy,
  output logic               done
);
  nco_state_e         r_state, w_state_nxt;
  nco_cfg_t           r_cfg;
  logic [ACC_W-1:0]   r_inc;
  logic [CNT_W-1:0]   r_idx;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_reload, r_done;
  logic [DWELL_W-1:0] w_dwell_in;
  logic [CNT_W:0]     w_idx_nxt, w_cnt;
  logic               w_wrap, w_msb, w_acc_en, w_acc_clr, w_hs;
  logic               w_ld_start, w_ld_step, w_ld_dwell;
  logic               w_set_reload, w_clr_reload, w_done;

  assign cfg_ready  = ((r_state == S_IDLE) || (r_state == S_FINAL)) && !abort;
  assign w_dwell_in = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
  assign w_idx_nxt  = {1'b0, r_idx} + (CNT_W+1)'(1);
  assign w_cnt      = {1'b0, r_cfg.count};

  assign clk_out   = w_msb;
  assign phase_inc = r_inc;
  assign step_idx  = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  nco_accum #(.ACC_W(ACC_W)) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_acc_en),
    .i_clr  (w_acc_clr),
    .i_inc  (r_inc),
    .o_wrap (w_wrap),
    .o_msb  (w_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_en     = 1'b0;
    w_acc_clr    = 1'b0;
    w_hs         = 1'b0;
    w_ld_start   = 1'b0;
    w_ld_step    = 1'b0;
    w_ld_dwell   = 1'b0;
    w_set_reload = 1'b0;
    w_clr_reload = 1'b0;
    w_done       = 1'b0;
    if (abort) begin
      w_state_nxt  = S_IDLE;
      w_acc_clr    = 1'b1;
      w_clr_reload = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_acc_clr = 1'b1;
          if (cfg_valid) begin
            w_hs        = 1'b1;
            w_state_nxt = (cfg_count != '0) ? S_DWELL : S_FINAL;
          end
        end
        S_DWELL: begin
          w_acc_en = 1'b1;
          if (r_dwell == DWELL_W'(1)) w_state_nxt = S_ARM;
        end
        S_ARM: begin
          w_acc_en = 1'b1;
          if (w_wrap) begin
            w_ld_dwell = 1'b1;
            if (r_reload) begin
              w_ld_start   = 1'b1;
              w_clr_reload = 1'b1;
              w_state_nxt  = (r_cfg.count == '0) ? S_FINAL : S_DWELL;
            end else if (w_idx_nxt < w_cnt) begin
              w_ld_step   = 1'b1;
              w_state_nxt = S_DWELL;
            end else if (w_idx_nxt == w_cnt) begin
              // Last step: a looping sweep still dwells on it before restarting.
              w_ld_step   = 1'b1;
              w_done      = !r_cfg.loop;
              w_state_nxt = r_cfg.loop ? S_DWELL : S_FINAL;
            end else begin
              w_ld_start  = 1'b1;
              w_done      = 1'b1;
              w_state_nxt = S_DWELL;
            end
          end
        end
        S_FINAL: begin
          w_acc_en = 1'b1;
          if (cfg_valid) begin
            w_hs         = 1'b1;
            w_set_reload = 1'b1;
            w_state_nxt  = S_ARM;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg    <= '0;
      r_inc    <= '0;
      r_idx    <= '0;
      r_dwell  <= '0;
      r_reload <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_hs)
        r_cfg <= '{start: cfg_start, step: cfg_step, count: cfg_count,
                   dwell: w_dwell_in, loop: cfg_loop};
      if (w_hs && (r_state == S_IDLE)) begin
        r_inc <= cfg_start;
        r_idx <= '0;
      end else if (w_ld_start) begin
        r_inc <= r_cfg.start;
        r_idx <= '0;
      end else if (w_ld_step) begin
        r_inc <= r_inc + r_cfg.step;
        r_idx <= r_idx + CNT_W'(1);
      end
      if (w_hs && (r_state == S_IDLE)) r_dwell <= w_dwell_in;
      else if (w_ld_dwell)             r_dwell <= r_cfg.dwell;
      else if (r_state == S_DWELL)     r_dwell <= r_dwell - DWELL_W'(1);
      if (w_clr_reload)      r_reload <= 1'b0;
      else if (w_set_reload) r_reload <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: sweep vectors with hand-derived increment-change
// timelines, plus abort and reconfigure-in-FINAL sequences.
module tb_nco_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0, cfg_loop = 1'b0, abort = 1'b0;
  logic [31:0] cfg_start = '0, cfg_step = '0;
  logic [7:0]  cfg_count = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_ready, clk_out, busy, done;
  logic [31:0] phase_inc;
  logic [7:0]  step_idx;

  nco_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_count(cfg_count),
    .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop), .abort(abort),
    .clk_out(clk_out), .phase_inc(phase_inc), .step_idx(step_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] inc;
    logic [7:0]  idx;
    logic        dn;
  } ev_t;

  typedef struct {
    logic [31:0]       start;
    logic [31:0]       step;
    logic [7:0]        count;
    logic [15:0]       dwell;
    logic              loop;
    int                win;
    int                nev;
    logic [0:3][7:0]   off;
    logic [0:3][31:0]  inc;
    logic [0:3][7:0]   idx;
    logic [0:3]        dn;
  } vec_t;

  ev_t         sb[$];
  vec_t        tbl[6];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] p_inc = '0;
  logic [7:0]  p_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One clock: wait for the falling edge, then match any output change.
  task automatic tick();
    ev_t e;
    @(negedge clk);
    if (rst_n && (phase_inc !== p_inc || step_idx !== p_idx || done === 1'b1)) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_event @cyc %0d: inc=%h idx=%0d done=%b", cyc, phase_inc, step_idx, done);
      end else begin
        e = sb.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        chk("event_phase_inc", phase_inc, e.inc);
        chk("event_step_idx", 32'(step_idx), 32'(e.idx));
        chk("event_done", 32'(done), 32'(e.dn));
      end
    end
    p_inc = phase_inc;
    p_idx = step_idx;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push(input int c, input logic [31:0] inc, input logic [7:0] idx, input logic dn);
    ev_t e;
    e.cyc = c; e.inc = inc; e.idx = idx; e.dn = dn;
    sb.push_back(e);
  endtask

  // Sets up a handshake for the coming edge; n is that edge's cycle number.
  task automatic drive_cfg(input logic [31:0] s, input logic [31:0] st, input logic [7:0] c,
                           input logic [15:0] d, input logic lp, output int n);
    chk("cfg_ready_before_hs", 32'(cfg_ready), 32'd1);
    cfg_start = s; cfg_step = st; cfg_count = c; cfg_dwell = d; cfg_loop = lp;
    cfg_valid = 1'b1;
    n = cyc + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic measure(input int ncyc, output int ones, output int rises);
    logic prev;
    ones = 0; rises = 0; prev = clk_out;
    repeat (ncyc) begin
      tick();
      if (clk_out) ones++;
      if (clk_out && !prev) rises++;
      prev = clk_out;
    end
  endtask

  initial begin
    int n, m, ones, rises;
    // two-point, loop restart, down-sweep to 0, 3-step up, degenerate, negative step with dwell 1
    tbl[0] = '{32'h4000_0000, 32'h4000_0000, 8'd1, 16'd8, 1'b0, 40, 2,
               '{8'd0, 8'd12, 8'd0, 8'd0}, '{32'h4000_0000, 32'h8000_0000, 32'h0, 32'h0},
               '{8'd0, 8'd1, 8'd0, 8'd0}, 4'b0100};
    tbl[1] = '{32'h4000_0000, 32'h4000_0000, 8'd1, 16'd8, 1'b1, 40, 4,
               '{8'd0, 8'd12, 8'd22, 8'd34},
               '{32'h4000_0000, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000},
               '{8'd0, 8'd1, 8'd0, 8'd1}, 4'b0010};
    tbl[2] = '{32'h1000_0000, 32'hF000_0000, 8'd1, 16'd4, 1'b0, 40, 2,
               '{8'd0, 8'd16, 8'd0, 8'd0}, '{32'h1000_0000, 32'h0, 32'h0, 32'h0},
               '{8'd0, 8'd1, 8'd0, 8'd0}, 4'b0100};
    tbl[3] = '{32'h1000_0000, 32'h1000_0000, 8'd3, 16'd2, 1'b0, 45, 4,
               '{8'd0, 8'd16, 8'd24, 8'd30},
               '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000},
               '{8'd0, 8'd1, 8'd2, 8'd3}, 4'b0001};
    tbl[4] = '{32'h2000_0000, 32'h0000_0001, 8'd0, 16'd0, 1'b0, 30, 1,
               '{8'd0, 8'd0, 8'd0, 8'd0}, '{32'h2000_0000, 32'h0, 32'h0, 32'h0},
               '{8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000};
    tbl[5] = '{32'h8000_0000, 32'hC000_0000, 8'd2, 16'd1, 1'b0, 20, 3,
               '{8'd0, 8'd2, 8'd6, 8'd0}, '{32'h8000_0000, 32'h4000_0000, 32'h0, 32'h0},
               '{8'd0, 8'd1, 8'd2, 8'd0}, 4'b0010};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_phase_inc", phase_inc, 32'd0);
    chk("reset_step_idx", 32'(step_idx), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      drive_cfg(tbl[i].start, tbl[i].step, tbl[i].count, tbl[i].dwell, tbl[i].loop, n);
      for (int k = 0; k < tbl[i].nev; k++)
        push(n + int'(tbl[i].off[k]), tbl[i].inc[k], tbl[i].idx[k], tbl[i].dn[k]);
      tick();
      cfg_valid = 1'b0;
      chk("vec_busy_after_hs", 32'(busy), 32'd1);
      wait_until(n + tbl[i].win);
      chk("vec_events_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end

    // Abort on the very cycle a wrap would apply the step, with a config offered.
    do_reset();
    drive_cfg(32'h4000_0000, 32'h4000_0000, 8'd1, 16'd8, 1'b0, n);
    push(n, 32'h4000_0000, 8'd0, 1'b0);
    tick();
    cfg_valid = 1'b0;
    wait_until(n + 11);
    chk("abort_pre_clk_out", 32'(clk_out), 32'd1);
    abort = 1'b1; cfg_valid = 1'b1; cfg_start = 32'h1234_5678; cfg_count = 8'd0;
    #1 chk("abort_ready_low", 32'(cfg_ready), 32'd0);
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_clk_out", 32'(clk_out), 32'd0);
    chk("abort_inc_kept", phase_inc, 32'h4000_0000);
    abort = 1'b0; cfg_valid = 1'b0;
    #1 chk("abort_ready_after", 32'(cfg_ready), 32'd1);
    repeat (4) tick();
    chk("abort_still_idle", 32'(busy), 32'd0);
    chk("abort_clk_out_low", 32'(clk_out), 32'd0);
    chk("abort_events_pending", 32'(sb.size()), 32'd0);

    // Degenerate config straight to FINAL, then reconfigure while running.
    do_reset();
    drive_cfg(32'h2000_0000, 32'h0, 8'd0, 16'd0, 1'b0, n);
    push(n, 32'h2000_0000, 8'd0, 1'b0);
    tick();
    cfg_valid = 1'b0;
    measure(16, ones, rises);
    chk("final_period8_high", 32'(ones), 32'd8);
    chk("final_period8_rises", 32'(rises), 32'd2);
    wait_until(n + 17);
    drive_cfg(32'h8000_0000, 32'h0, 8'd1, 16'd3, 1'b0, m);
    push(n + 24, 32'h8000_0000, 8'd0, 1'b0);
    push(n + 28, 32'h8000_0000, 8'd1, 1'b1);
    tick();
    cfg_valid = 1'b0;
    chk("reconf_busy", 32'(busy), 32'd1);
    chk("reconf_inc_held", phase_inc, 32'h2000_0000);
    wait_until(n + 23);
    chk("reconf_inc_before_wrap", phase_inc, 32'h2000_0000);
    wait_until(n + 28);
    measure(8, ones, rises);
    chk("reconf_period2_high", 32'(ones), 32'd4);
    chk("reconf_period2_rises", 32'(rises), 32'd4);
    abort = 1'b1; cfg_valid = 1'b1; cfg_start = 32'h0000_0001; cfg_count = 8'd1;
    #1 chk("final_abort_ready_low", 32'(cfg_ready), 32'd0);
    tick();
    abort = 1'b0; cfg_valid = 1'b0;
    chk("final_abort_busy", 32'(busy), 32'd0);
    chk("final_abort_inc_kept", phase_inc, 32'h8000_0000);
    tick();
    chk("final_abort_clk_out", 32'(clk_out), 32'd0);
    chk("reconf_events_pending", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
